// File: rtl/spk_in_pkg.sv
// Shared flit-receiver constants: default widths, flit type codes and FSM state encodings.
package spk_in_pkg;

  localparam int unsigned DEF_B     = 4;
  localparam int unsigned DEF_FW    = 59;
  localparam int unsigned DEF_FTW   = 3;
  localparam int unsigned DEF_SW    = 24;
  localparam int unsigned DEF_R_FLG = 36;

  localparam logic [2:0] T_SPIKE    = 3'b000;
  localparam logic [2:0] T_DATA     = 3'b001;
  localparam logic [2:0] T_DATA_END = 3'b010;
  localparam logic [2:0] T_WRITE    = 3'b110;
  localparam logic [2:0] T_READ     = 3'b111;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_OUT  = 2'b10;

  function automatic logic is_bad_type(input logic [2:0] t);
    return !(t inside {T_SPIKE, T_DATA, T_DATA_END, T_WRITE, T_READ});
  endfunction

endpackage

// File: rtl/spk_in_if.sv
// Flit ingress, credit return and spike/config dispatch signals of the node-side receiver.
interface spk_in_if import spk_in_pkg::*; #(
  parameter int unsigned FW    = DEF_FW,
  parameter int unsigned FTW   = DEF_FTW,
  parameter int unsigned SW    = DEF_SW,
  parameter int unsigned R_FLG = DEF_R_FLG
) ();

  logic             flit_in_wr;
  logic [FW-1:0]    flit_in;
  logic             credit_out;
  logic             spk_in_valid;
  logic [SW-1:0]    spk_in_neuid;
  logic             spk_in_ready;
  logic             cfg_in_valid;
  logic [FTW-1:0]   cfg_in_type;
  logic [R_FLG-1:0] cfg_in_data;
  logic             cfg_in_ready;

  // Sender/consumer side (NI plus synapse/config units).
  modport master (
    output flit_in_wr, flit_in, spk_in_ready, cfg_in_ready,
    input  credit_out, spk_in_valid, spk_in_neuid, cfg_in_valid, cfg_in_type, cfg_in_data
  );

  // Receiver side.
  modport slave (
    input  flit_in_wr, flit_in, spk_in_ready, cfg_in_ready,
    output credit_out, spk_in_valid, spk_in_neuid, cfg_in_valid, cfg_in_type, cfg_in_data
  );

endinterface

// File: rtl/spk_in_fifo.sv
// Synchronous FIFO with a registered read port: dout updates one cycle after pop.
module spk_in_fifo #(
  parameter int unsigned DATA_WIDTH = 59,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  do_push, do_pop;

  assign full    = (count_q == (ADDR_WIDTH+1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = dout_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
        dout_q   <= mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spk_in.sv
// Node-side flit receiver: buffers NI flits, returns one credit per pop and dispatches
// SPIKE ids to the synapse side and WRITE/DATA/DATA_END/READ payloads to the config block.
module spk_in import spk_in_pkg::*; #(
  parameter int unsigned B     = DEF_B,
  parameter int unsigned FW    = DEF_FW,
  parameter int unsigned FTW   = DEF_FTW,
  parameter int unsigned SW    = DEF_SW,
  parameter int unsigned R_FLG = DEF_R_FLG
) (
  input  logic    clk_spk_in,
  input  logic    rst_n,
  spk_in_if.slave bus,
  output logic    spk_in_overflow,
  output logic    spk_in_bad_type
);

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0]    fifo_dout;
  logic [FTW-1:0]   dout_type;
  logic [1:0]       state_q, state_d;
  logic [FTW-1:0]   type_q;
  logic [R_FLG-1:0] payload_q;
  logic             load, bad_seen, is_spike, handshake, out_active;
  logic             overflow_q, bad_type_q;
  logic             unused_route;

  spk_in_fifo #(
    .DATA_WIDTH(FW),
    .ADDR_WIDTH(B)
  ) u_fifo (
    .clk   (clk_spk_in),
    .rst_n (rst_n),
    .push  (bus.flit_in_wr),
    .din   (bus.flit_in),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign dout_type    = fifo_dout[FW-1 -: FTW];
  // Routing field is meaningless once the flit has reached its node.
  assign unused_route = ^fifo_dout[FW-FTW-1:R_FLG];

  assign is_spike   = (type_q == T_SPIKE);
  assign out_active = (state_q == S_OUT);
  assign handshake  = is_spike ? bus.spk_in_ready : bus.cfg_in_ready;

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    bad_seen = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (is_bad_type(dout_type)) begin
          // Drop the flit but keep draining; its credit was already returned on pop.
          bad_seen = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          load    = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (handshake) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_spk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      type_q     <= '0;
      payload_q  <= '0;
      overflow_q <= 1'b0;
      bad_type_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        type_q    <= dout_type;
        payload_q <= fifo_dout[R_FLG-1:0];
      end
      overflow_q <= overflow_q | (bus.flit_in_wr & fifo_full);
      bad_type_q <= bad_type_q | bad_seen;
    end
  end

  assign bus.credit_out   = fifo_pop;
  assign bus.spk_in_valid = out_active & is_spike;
  assign bus.spk_in_neuid = payload_q[SW-1:0];
  assign bus.cfg_in_valid = out_active & ~is_spike;
  assign bus.cfg_in_type  = type_q;
  assign bus.cfg_in_data  = payload_q;
  assign spk_in_overflow  = overflow_q;
  assign spk_in_bad_type  = bad_type_q;

endmodule
